// File: rtl/ram_bist_ctrl_if.sv
// RAM-side bus of the BIST controller: write port plus read address/data of a simple-dual-port RAM.
// The controller takes the master modport and the RAM (or its model) takes the slave modport.
interface ram_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/ram_bist_ctrl.sv
// BIST controller for a simple-dual-port RAM: it writes a pattern, reads it back and counts mismatches.
// Optional RAM_BIST_FAULT_INJ_EN adds ports that flip bit 0 of one written word to self-test the checker.
module ram_bist_ctrl #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 2,
    parameter int ERR_CNT_WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [1:0]               i_pattern_sel,
`ifdef RAM_BIST_FAULT_INJ_EN
    input  logic                     i_inj_en,
    input  logic [ADDR_WIDTH-1:0]    i_inj_addr,
`endif
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic [ADDR_WIDTH-1:0]    o_first_err_addr,
    ram_bist_ctrl_if.master          ram
);

    localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0]    DRAIN_LAST = ADDR_WIDTH'(RD_LATENCY - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = {ERR_CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                          r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]           r_addr, w_addr_nxt;
    logic                            w_accept;
    logic [1:0]                      r_pat;
    logic [ERR_CNT_WIDTH-1:0]        r_err_cnt;
    logic [ADDR_WIDTH-1:0]           r_first_err;
    logic [RD_LATENCY:1]             r_vld_pipe;
    logic [RD_LATENCY:1][ADDR_WIDTH-1:0] r_addr_pipe;
    logic [DATA_WIDTH-1:0]           w_exp;
    logic                            w_mis;
    logic                            w_inj;

    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [1:0] sel,
                                                        input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        case (sel)
            2'd0: d = {DATA_WIDTH{1'b1}} - DATA_WIDTH'(a);
            2'd1: d = DATA_WIDTH'(a);
            default: begin
                for (int i = 0; i < DATA_WIDTH; i++) d[i] = 1'(i % 2) ^ a[0];
                if (sel == 2'd3) d = ~d;
            end
        endcase
        return d;
    endfunction

    // r_addr doubles as the drain-cycle counter: it wraps to 0 on entering DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WRITE;
                    w_addr_nxt  = '0;
                end
            end
            S_WRITE: begin
                w_addr_nxt = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) w_state_nxt = S_READ;
            end
            S_READ: begin
                w_addr_nxt = r_addr + 1'b1;
                if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_addr_nxt = r_addr + 1'b1;
                if (r_addr == DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                    w_addr_nxt  = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef RAM_BIST_FAULT_INJ_EN
    logic                  r_inj_en;
    logic [ADDR_WIDTH-1:0] r_inj_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_inj_en   <= 1'b0;
            r_inj_addr <= '0;
        end else if (w_accept) begin
            r_inj_en   <= i_inj_en;
            r_inj_addr <= i_inj_addr;
        end
    end

    assign w_inj = r_inj_en && (r_addr == r_inj_addr);
`else
    assign w_inj = 1'b0;
`endif

    assign w_exp = f_pattern(r_pat, r_addr_pipe[RD_LATENCY]);
    assign w_mis = r_vld_pipe[RD_LATENCY] && (ram.rd_data != w_exp);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_pat       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_vld_pipe  <= '0;
            r_addr_pipe <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_vld_pipe[1]  <= (r_state == S_READ);
            r_addr_pipe[1] <= r_addr;
            for (int k = 2; k <= RD_LATENCY; k++) begin
                r_vld_pipe[k]  <= r_vld_pipe[k-1];
                r_addr_pipe[k] <= r_addr_pipe[k-1];
            end
            if (w_accept) begin
                r_pat       <= i_pattern_sel;
                r_err_cnt   <= '0;
                r_first_err <= '0;
            end else if (w_mis) begin
                if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
                if (r_err_cnt == '0) r_first_err <= r_addr_pipe[RD_LATENCY];
            end
        end
    end

    assign o_busy           = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign o_done           = (r_state == S_DONE);
    assign o_pass           = o_done && (r_err_cnt == '0);
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_addr = r_first_err;

    assign ram.wr_en   = (r_state == S_WRITE);
    assign ram.wr_addr = ram.wr_en ? r_addr : '0;
    assign ram.wr_data = ram.wr_en ? (f_pattern(r_pat, r_addr) ^ {{(DATA_WIDTH-1){1'b0}}, w_inj}) : '0;
    assign ram.rd_addr = (r_state == S_READ) ? r_addr : '0;

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Parametrised built-in self-test controller for a single-clock simple-dual-port block RAM (SDP RAM IP core, optional output register).
- On `start`, fills every RAM address with a selectable data pattern, reads all addresses back, compares against the expected value at the configured read latency, then reports pass/fail, error count and first failing address.
- Sits beside the RAM IP in board demos and bring-up designs. Replaces hand-written per-core testbench sequencing with synthesizable on-chip test logic.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width (≥2).
- RD_LATENCY, 2, cycles from `ram_rd_addr` to valid `ram_rd_data`. Legal values: 1 (no output reg) or 2 (output reg).
- ERR_CNT_WIDTH, 4, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE or DONE.
- pattern_sel  in  2  0=down-count, 1=address, 2=checkerboard, 3=inverted checkerboard; sampled on accept.
- busy  out  1  test in progress.
- done  out  1  test complete; held until next accepted start.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  ERR_CNT_WIDTH  mismatches, saturating at all-ones.
- first_err_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data.

Behaviour:
- Single clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset (any state, including mid-test):
  - Next edge → IDLE.
  - All outputs 0; internal counters and compare pipeline cleared.
- FSM: IDLE → WRITE → READ → DRAIN → DONE.
  - IDLE/DONE, start=1: latch pattern_sel; clear err_cnt, first_err_addr, done and pass; busy=1; enter WRITE with address 0.
  - WRITE: one write per cycle (ram_wr_en=1), address 0…DEPTH-1. After the DEPTH-1 write → READ; ram_wr_en=0.
  - READ: ram_rd_addr 0…DEPTH-1, one per cycle. After the last address → DRAIN.
  - DRAIN: RD_LATENCY cycles to flush the compare pipeline → DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0).
- start while busy: ignored, no effect.
- Busy duration: exactly 2*DEPTH + RD_LATENCY cycles.
- Pattern for address a, bit i:
  - 0: data = all-ones − a (addr 0 → all-ones).
  - 1: data = a, zero-extended or truncated to DATA_WIDTH.
  - 2: bit i = i[0] XOR a[0] (DW=8: even addr 0xAA, odd addr 0x55).
  - 3: bitwise inverse of pattern 2.
- Compare pipeline:
  - Read address and a valid flag go through an RD_LATENCY-deep shift register.
  - When the delayed valid=1: expected = pattern(delayed addr); mismatch if ram_rd_data ≠ expected.
- Error recording:
  - On mismatch: err_cnt += 1, saturating at 2**ERR_CNT_WIDTH−1.
  - On the first mismatch of a run: first_err_addr = delayed addr.
- Address counters wrap naturally; the terminal condition is detected at DEPTH-1, not via overflow.
- Read and write never overlap, so there is no read-during-write hazard.

Optional Feature:
- Macro: RAM_BIST_FAULT_INJ_EN.
- Defined:
  - Adds inputs `inj_en` (1) and `inj_addr` (ADDR_WIDTH), sampled on start accept.
  - If inj_en=1, the write to inj_addr has bit 0 inverted; the comparison still uses the true pattern.
  - A healthy RAM must then report exactly err_cnt=1 and first_err_addr=inj_addr.
- Undefined: ports absent; no data modification.

Test Plan:
- DW=8, AW=6, RD_LATENCY=2, ideal RAM, start with pattern 0 → busy high 130 cycles; writes addr0=0xFF, addr63=0xC0; done=1, pass=1, err_cnt=0.
- Pattern 2, RAM model with bit3 stuck-at-1 at addr 17 → readback 0x5D vs expected 0x55; err_cnt=1, first_err_addr=17, pass=0.
- Pattern 1, RAM model with data bit0 stuck-at-0 on every address → 32 mismatches; err_cnt saturates at 15, first_err_addr=1, pass=0.
- start pulsed at busy cycle 50 → ignored, total busy still 130. rst_n low at WRITE cycle 20 → next edge: busy=0, ram_wr_en=0, done=0, err_cnt=0, state IDLE.
- RD_LATENCY=1, no-output-reg RAM model, pattern 3 → busy 129 cycles; pass=1.
- RAM_BIST_FAULT_INJ_EN defined, inj_en=1, inj_addr=42, pattern 0 → err_cnt=1, first_err_addr=42, pass=0. Rerun with inj_en=0 → pass=1.
